rx_cmd_decoder: RTL and testbench
=================================

RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

Interface
REQ-001 Parameter DATA_W, 8, width of received frame bytes and register-file data.
REQ-002 Parameter ADDR_W, 4, register-file address width.
REQ-003 Parameter TIMEOUT_CYC, 255, max idle cycles between frame bytes (used only with CMD_TIMEOUT_EN).
REQ-004 CLK  in  1  single clock; all logic on rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 rx_data  in  DATA_W  synchronized byte, valid only when rx_valid=1.
REQ-007 rx_valid  in  1  single-cycle pulse marking a new byte on rx_data.
REQ-008 rf_rd_data  in  DATA_W  register-file read data.
REQ-009 rf_rd_valid  in  1  read-data-valid pulse from the register file.
REQ-010 alu_out  in  2*DATA_W  ALU result.
REQ-011 alu_valid  in  1  ALU result-valid pulse.
REQ-012 tx_busy  in  1  transmitter busy; when 1, no tx_valid is issued.
REQ-013 rf_addr  out  ADDR_W  register-file address.
REQ-014 rf_wr_en / rf_rd_en  out  1 each  single-cycle write and read strobes.
REQ-015 rf_wr_data  out  DATA_W  register-file write data.
REQ-016 alu_fun  out  4  ALU function code; alu_en  out  1  single-cycle ALU start strobe.
REQ-017 tx_data  out  DATA_W  response byte; tx_valid  out  1  single-cycle send strobe.
REQ-018 cmd_err  out  1  single-cycle pulse on an unknown opcode or timeout abort.

Function
REQ-019 Opcodes: 0xAA = write (addr, data); 0xBB = read (addr); 0xCC = ALU with operands (A, B, fun); 0xDD = ALU without operands (fun); any other byte in IDLE pulses cmd_err and stays IDLE.
REQ-020 States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI; each byte state advances only on rx_valid.
REQ-021 Address bytes latch rx_data[ADDR_W-1:0]; upper bits are ignored.
REQ-022 Write: on the data byte, rf_wr_en pulses for one cycle, registered one cycle after rx_valid, then the FSM returns to IDLE; no response is sent.
REQ-023 Read: on the addr byte, rf_rd_en pulses; RD_WAIT holds until rf_rd_valid, then the FSM captures rf_rd_data and enters TX_LO.
REQ-024 ALU 0xCC: byte A is written to rf_addr 0, byte B to rf_addr 1 (one rf_wr_en each); the fun byte drives alu_fun=rx_data[3:0] and pulses alu_en.
REQ-025 ALU 0xDD: the next byte is treated as fun, and the FSM proceeds as in ALU_FUN.
REQ-026 ALU_WAIT holds until alu_valid, then captures alu_out; TX_LO sends the low byte, then TX_HI sends the high byte.
REQ-027 TX states pulse tx_valid in the first cycle where tx_busy=0, then advance; read responses skip TX_HI.
REQ-028 rx_valid arriving in RD_WAIT, ALU_WAIT or a TX state is dropped silently.
REQ-029 All strobes are mutually exclusive per cycle and never assert for more than one cycle.

Reset
REQ-030 While RST=1: FSM enters IDLE and all outputs and captured registers are 0, immediately and asynchronously.
REQ-031 Reset mid-frame discards the partial frame; the first byte after release is decoded as an opcode.

Configuration
REQ-032 With CMD_TIMEOUT_EN defined: an inter-byte counter runs in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B and ALU_FUN, clears on rx_valid, and on reaching TIMEOUT_CYC pulses cmd_err and returns the FSM to IDLE.
REQ-033 Without CMD_TIMEOUT_EN: no counter exists, and byte states wait indefinitely.

Structure
REQ-034 Shared package rx_cmd_pkg holds the opcode constants and the state enumeration.
REQ-035 One sub-module, rx_cmd_timeout, holds the inter-byte counter and is instantiated only under CMD_TIMEOUT_EN.

Verification
REQ-036 Bytes AA,05,3C -> one rf_wr_en with rf_addr=5, rf_wr_data=0x3C; no tx_valid.
REQ-037 Bytes BB,05; rf_rd_valid with data 0x3C -> rf_rd_en at addr 5; one tx_valid with tx_data=0x3C.
REQ-038 Bytes CC,10,20,00; alu_valid with 0x0030 and tx_busy=1 for 3 cycles -> writes to addr 0 and 1, alu_fun=0, tx_valid 0x30 after busy drops, then tx_valid 0x00.
REQ-039 Byte 0x55 in IDLE -> cmd_err for one cycle; then DD,01 -> alu_en with alu_fun=1.
REQ-040 RST asserted after AA,05 -> all outputs 0; then AA,02,11 -> a normal write to addr 2.
REQ-041 CMD_TIMEOUT_EN with TIMEOUT_CYC=10: AA followed by 10 idle cycles -> cmd_err and IDLE; a following BB is accepted as an opcode.

Source files
------------

// File: rtl/rx_cmd_pkg.sv
// Shared opcode constants and FSM state encoding for rx_cmd_decoder.
package rx_cmd_pkg;

  localparam logic [7:0] OP_WR     = 8'hAA;
  localparam logic [7:0] OP_RD     = 8'hBB;
  localparam logic [7:0] OP_ALU    = 8'hCC;
  localparam logic [7:0] OP_ALU_NO = 8'hDD;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_A,
    ST_ALU_B,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_LO,
    ST_TX_HI
  } state_t;

  // States that are waiting for the next frame byte.
  function automatic logic is_byte_state(state_t s);
    return s inside {ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_ALU_A, ST_ALU_B, ST_ALU_FUN};
  endfunction

endpackage

// File: rtl/rx_cmd_timeout.sv
// Inter-byte idle counter; expired flags the idle cycle that reaches TIMEOUT_CYC.
module rx_cmd_timeout #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic active,
  input  logic rx_valid,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (!active || rx_valid) begin
      cnt <= '0;
    end else if (cnt != CW'(TIMEOUT_CYC)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = active && !rx_valid && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/rx_cmd_decoder.sv
// Byte-stream command decoder driving a register file and ALU, returning results over tx.
// Optional inter-byte timeout enabled with `define CMD_TIMEOUT_EN.
module rx_cmd_decoder
  import rx_cmd_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_valid,
  input  logic [DATA_W-1:0]   rf_rd_data,
  input  logic                rf_rd_valid,
  input  logic [2*DATA_W-1:0] alu_out,
  input  logic                alu_valid,
  input  logic                tx_busy,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic                rf_wr_en,
  output logic                rf_rd_en,
  output logic [DATA_W-1:0]   rf_wr_data,
  output logic [3:0]          alu_fun,
  output logic                alu_en,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_valid,
  output logic                cmd_err,
  output state_t              state_dbg
);

  state_t              state;
  logic [2*DATA_W-1:0] result;
  logic                is_read;
  logic                timeout_hit;

`ifdef CMD_TIMEOUT_EN
  rx_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .CLK      (CLK),
    .RST      (RST),
    .active   (is_byte_state(state)),
    .rx_valid (rx_valid),
    .expired  (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

  assign state_dbg = state;

  // Strobes default low every cycle so each one is a single-cycle pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      result     <= '0;
      is_read    <= 1'b0;
      rf_addr    <= '0;
      rf_wr_en   <= 1'b0;
      rf_rd_en   <= 1'b0;
      rf_wr_data <= '0;
      alu_fun    <= '0;
      alu_en     <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
      if (timeout_hit) begin
        cmd_err <= 1'b1;
        state   <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: if (rx_valid) begin
            if (rx_data == DATA_W'(OP_WR))          state <= ST_WR_ADDR;
            else if (rx_data == DATA_W'(OP_RD))     state <= ST_RD_ADDR;
            else if (rx_data == DATA_W'(OP_ALU))    state <= ST_ALU_A;
            else if (rx_data == DATA_W'(OP_ALU_NO)) state <= ST_ALU_FUN;
            else                                    cmd_err <= 1'b1;
          end
          ST_WR_ADDR: if (rx_valid) begin
            rf_addr <= rx_data[ADDR_W-1:0];
            state   <= ST_WR_DATA;
          end
          ST_WR_DATA: if (rx_valid) begin
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
            state      <= ST_IDLE;
          end
          ST_RD_ADDR: if (rx_valid) begin
            rf_addr  <= rx_data[ADDR_W-1:0];
            rf_rd_en <= 1'b1;
            state    <= ST_RD_WAIT;
          end
          ST_RD_WAIT: if (rf_rd_valid) begin
            result  <= {{DATA_W{1'b0}}, rf_rd_data};
            is_read <= 1'b1;
            state   <= ST_TX_LO;
          end
          ST_ALU_A: if (rx_valid) begin
            rf_addr    <= '0;
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
            state      <= ST_ALU_B;
          end
          ST_ALU_B: if (rx_valid) begin
            rf_addr    <= ADDR_W'(1);
            rf_wr_data <= rx_data;
            rf_wr_en   <= 1'b1;
            state      <= ST_ALU_FUN;
          end
          ST_ALU_FUN: if (rx_valid) begin
            alu_fun <= rx_data[3:0];
            alu_en  <= 1'b1;
            state   <= ST_ALU_WAIT;
          end
          ST_ALU_WAIT: if (alu_valid) begin
            result  <= alu_out;
            is_read <= 1'b0;
            state   <= ST_TX_LO;
          end
          // A one-cycle gap after each send keeps tx_valid from being two cycles wide.
          ST_TX_LO: if (!tx_busy && !tx_valid) begin
            tx_data  <= result[DATA_W-1:0];
            tx_valid <= 1'b1;
            state    <= is_read ? ST_IDLE : ST_TX_HI;
          end
          ST_TX_HI: if (!tx_busy && !tx_valid) begin
            tx_data  <= result[2*DATA_W-1:DATA_W];
            tx_valid <= 1'b1;
            state    <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// Directed bench for rx_cmd_decoder; outputs are sampled on the falling clock edge.
module tb_rx_cmd_decoder;
  import rx_cmd_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
`ifdef CMD_TIMEOUT_EN
  localparam int TB_TO = 10;
`else
  localparam int TB_TO = 255;
`endif

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [DATA_W-1:0]   rx_data = '0;
  logic                rx_valid = 1'b0;
  logic [DATA_W-1:0]   rf_rd_data = '0;
  logic                rf_rd_valid = 1'b0;
  logic [2*DATA_W-1:0] alu_out = '0;
  logic                alu_valid = 1'b0;
  logic                tx_busy = 1'b0;
  logic [ADDR_W-1:0]   rf_addr;
  logic                rf_wr_en;
  logic                rf_rd_en;
  logic [DATA_W-1:0]   rf_wr_data;
  logic [3:0]          alu_fun;
  logic                alu_en;
  logic [DATA_W-1:0]   tx_data;
  logic                tx_valid;
  logic                cmd_err;
  state_t              state_dbg;

  int n_assert = 0;
  int n_fail   = 0;
  int n_tx     = 0;
  int n_viol   = 0;
  logic [4:0] prev_strb = '0;

  rx_cmd_decoder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TB_TO)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .alu_out(alu_out),
    .alu_valid(alu_valid), .tx_busy(tx_busy), .rf_addr(rf_addr),
    .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en), .rf_wr_data(rf_wr_data),
    .alu_fun(alu_fun), .alu_en(alu_en), .tx_data(tx_data), .tx_valid(tx_valid),
    .cmd_err(cmd_err), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Strobe watcher: one strobe at a time, none held for two samples.
  always @(negedge CLK) begin
    if (RST) begin
      prev_strb <= '0;
    end else begin
      if ($countones({rf_wr_en, rf_rd_en, alu_en, tx_valid, cmd_err}) > 1 ||
          (({rf_wr_en, rf_rd_en, alu_en, tx_valid, cmd_err} & prev_strb) != '0))
        n_viol <= n_viol + 1;
      if (tx_valid) n_tx <= n_tx + 1;
      prev_strb <= {rf_wr_en, rf_rd_en, alu_en, tx_valid, cmd_err};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic send_byte(input logic [DATA_W-1:0] b);
    @(negedge CLK);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_alu(input logic [2*DATA_W-1:0] v);
    alu_out   = v;
    alu_valid = 1'b1;
    @(negedge CLK);
    alu_valid = 1'b0;
  endtask

  task automatic pulse_rd(input logic [DATA_W-1:0] v);
    rf_rd_data  = v;
    rf_rd_valid = 1'b1;
    @(negedge CLK);
    rf_rd_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {rf_addr, rf_wr_en, rf_rd_en, rf_wr_data, alu_fun, alu_en,
                         tx_data, tx_valid, cmd_err}, '0);
    chk({tag, "_state"}, state_dbg, ST_IDLE);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    RST = 1'b0;

    // Write AA,05,3C
    send_byte(8'hAA);
    send_byte(8'h05);
    send_byte(8'h3C);
    chk("wr_en", rf_wr_en, 1);
    chk("wr_addr", rf_addr, 5);
    chk("wr_data", rf_wr_data, 8'h3C);
    @(negedge CLK);
    chk("wr_en_drop", rf_wr_en, 0);
    chk("wr_no_tx", n_tx, 0);

    // Write with upper address bits set
    send_byte(8'hAA);
    send_byte(8'hF7);
    send_byte(8'h5A);
    chk("wr_hi_addr", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h7, 8'h5A});

    // Read BB,05 -> 3C
    send_byte(8'hBB);
    send_byte(8'h05);
    chk("rd_en", {rf_rd_en, rf_addr}, {1'b1, 4'h5});
    @(negedge CLK);
    chk("rd_wait", {tx_valid, state_dbg}, {1'b0, ST_RD_WAIT});
    pulse_rd(8'h3C);
    @(negedge CLK);
    chk("rd_tx", {tx_valid, tx_data}, {1'b1, 8'h3C});
    @(negedge CLK);
    chk("rd_done", {tx_valid, state_dbg}, {1'b0, ST_IDLE});

    // ALU CC,10,20,00 with tx_busy held
    tx_busy = 1'b1;
    send_byte(8'hCC);
    send_byte(8'h10);
    chk("alu_a", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h0, 8'h10});
    send_byte(8'h20);
    chk("alu_b", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h1, 8'h20});
    send_byte(8'h00);
    chk("alu_en_cc", {alu_en, alu_fun}, {1'b1, 4'h0});
    pulse_alu(16'h0030);
    chk("busy_1", tx_valid, 0);
    @(negedge CLK);
    chk("busy_2", tx_valid, 0);
    @(negedge CLK);
    chk("busy_3", tx_valid, 0);
    tx_busy = 1'b0;
    @(negedge CLK);
    chk("cc_tx_lo", {tx_valid, tx_data}, {1'b1, 8'h30});
    @(negedge CLK);
    chk("cc_gap", tx_valid, 0);
    @(negedge CLK);
    chk("cc_tx_hi", {tx_valid, tx_data}, {1'b1, 8'h00});
    @(negedge CLK);
    chk("cc_done", state_dbg, ST_IDLE);

    // Unknown opcode, then DD,01 with a dropped byte in ALU_WAIT
    send_byte(8'h55);
    chk("bad_op", {cmd_err, state_dbg}, {1'b1, ST_IDLE});
    @(negedge CLK);
    chk("bad_op_drop", cmd_err, 0);
    send_byte(8'hDD);
    chk("dd_state", state_dbg, ST_ALU_FUN);
    send_byte(8'h01);
    chk("alu_en_dd", {alu_en, alu_fun}, {1'b1, 4'h1});
    send_byte(8'hAA);
    chk("drop_in_wait", state_dbg, ST_ALU_WAIT);
    pulse_alu(16'h1234);
    @(negedge CLK);
    chk("dd_tx_lo", {tx_valid, tx_data}, {1'b1, 8'h34});
    repeat (2) @(negedge CLK);
    chk("dd_tx_hi", {tx_valid, tx_data}, {1'b1, 8'h12});
    @(negedge CLK);
    chk("dd_done", state_dbg, ST_IDLE);

    // Reset mid-frame
    send_byte(8'hAA);
    send_byte(8'h05);
    RST = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    @(negedge CLK);
    RST = 1'b0;
    send_byte(8'hAA);
    send_byte(8'h02);
    send_byte(8'h11);
    chk("post_rst_wr", {rf_wr_en, rf_addr, rf_wr_data}, {1'b1, 4'h2, 8'h11});

`ifdef CMD_TIMEOUT_EN
    send_byte(8'hAA);
    for (int i = 0; i < TB_TO - 1; i++) begin
      @(negedge CLK);
      chk("to_early", cmd_err, 0);
    end
    @(negedge CLK);
    chk("to_err", {cmd_err, state_dbg}, {1'b1, ST_IDLE});
    send_byte(8'hBB);
    send_byte(8'h05);
    chk("to_next_rd", {rf_rd_en, rf_addr}, {1'b1, 4'h5});
    pulse_rd(8'h77);
    @(negedge CLK);
    chk("to_rd_tx", {tx_valid, tx_data}, {1'b1, 8'h77});
    @(negedge CLK);
    chk("tx_total", n_tx, 6);
`else
    @(negedge CLK);
    chk("tx_total", n_tx, 5);
`endif
    chk("strobe_rules", n_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
